pwm_bank: RTL
=============

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 10, meaning number of PWM outputs (1..16).
REQ-002 SHALL have parameter WIDTH, default 8, meaning duty/counter resolution in bits (4..16).
REQ-003 SHALL have parameter PRESCALE, default 2, meaning clk50M cycles per counter tick (>=1).
REQ-004 SHALL have parameter WD_PERIODS, default 0, meaning PWM periods without a write before fail-safe (0 = watchdog off).
REQ-005 SHALL have port clk50M, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port wr_valid, input, 1, meaning a duty write is presented.
REQ-008 SHALL have port wr_ready, output, 1, meaning the block accepts a write this cycle.
REQ-009 SHALL have port wr_chan, input, 4, meaning target channel index.
REQ-010 SHALL have port wr_duty, input, WIDTH, meaning requested duty code.
REQ-011 SHALL have port wr_err, output, 1, meaning one-cycle pulse when a write names a channel >= CHANNELS.
REQ-012 SHALL have port pwm_out, output, CHANNELS, meaning registered PWM outputs.
REQ-013 SHALL have port period_start, output, 1, meaning one-cycle pulse at each counter wrap.
REQ-014 SHALL have port wd_trip, output, 1, meaning watchdog fail-safe is active.

Function
REQ-015 SHALL advance a prescaler every cycle and issue a tick every PRESCALE cycles; counter cnt (WIDTH bits) SHALL increment on tick and wrap from 2^WIDTH-1 to 0.
REQ-016 SHALL pulse period_start for exactly one cycle on the tick where cnt wraps to 0.
REQ-017 SHALL drive pwm_out[i] = (cnt < active[i]), registered (one cycle latency from cnt); active = 0 gives constant low; active = all-ones gives constant high (special case, 100 %).
REQ-018 SHALL hold wr_ready = 1 in every cycle except during rst.
REQ-019 SHALL, on wr_valid & wr_ready with wr_chan < CHANNELS, write wr_duty into target[wr_chan] at that clock edge.
REQ-020 SHALL, on wr_valid & wr_ready with wr_chan >= CHANNELS, leave all targets unchanged and pulse wr_err the next cycle.
REQ-021 SHALL update active[i] from target[i] only in the cycle period_start is asserted (glitch-free, whole periods only).
REQ-022 SHALL, when a write and period_start coincide, load active from the pre-write target; the new value takes effect at the following period_start.
REQ-023 SHALL, with WD_PERIODS > 0, count period_start pulses since the last accepted valid-channel write and, on reaching WD_PERIODS, clear all target and active to 0 and set wd_trip.
REQ-024 SHALL clear wd_trip and the watchdog count on the next accepted valid-channel write; wd_trip SHALL never set when WD_PERIODS = 0.

Reset
REQ-025 SHALL, while rst is high, clear prescaler, cnt, all target/active, watchdog count, wr_ready, wr_err, period_start, wd_trip and pwm_out to 0.
REQ-026 SHALL discard a write presented in the cycle rst is high; a reset mid-period SHALL restart the period at cnt = 0 with all outputs low.

Configuration
REQ-027 SHALL, with macro PWM_BANK_RAMP_EN defined, add parameter RAMP_STEP (default 4) and move active[i] toward target[i] by at most RAMP_STEP per period_start, saturating exactly at target (no overshoot, no wrap).
REQ-028 SHALL, without PWM_BANK_RAMP_EN, load active[i] = target[i] in a single period_start; watchdog clearing SHALL bypass ramping in both builds.

Verification
REQ-029 SHALL test: defaults, write chan 3 duty 64 -> from next period pwm_out[3] high 64 of 256 ticks (128 clk50M cycles), other outputs low.
REQ-030 SHALL test: write duty 255 to chan 0, duty 0 to chan 1 -> pwm_out[0] constant high, pwm_out[1] constant low across a full period.
REQ-031 SHALL test: write chan 12 duty 10 -> wr_err one-cycle pulse, no output changes.
REQ-032 SHALL test: write issued in period_start cycle, 100 -> 200 -> high time stays 100 for that period, 200 in the next.
REQ-033 SHALL test: WD_PERIODS = 3, duty 128, no further writes -> wd_trip set and all outputs low after third period_start; a new write clears wd_trip.
REQ-034 SHALL test: PWM_BANK_RAMP_EN, RAMP_STEP 4, target 0 -> 10 -> active 4, 8, 10 on successive periods.

Source files
------------

// File: rtl/pwm_bank.sv
// Bank of CHANNELS PWM outputs sharing one prescaled counter. Duty changes are applied only at period boundaries.
// Optional macro PWM_BANK_RAMP_EN slews each active duty toward its target by RAMP_STEP per period.
module pwm_bank #(
  parameter int CHANNELS   = 10,
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 2,
  parameter int WD_PERIODS = 0
`ifdef PWM_BANK_RAMP_EN
  ,
  parameter int RAMP_STEP  = 4
`endif
) (
  input  logic                clk50M,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [3:0]          wr_chan,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic                wr_err,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start,
  output logic                wd_trip
);

  localparam int PS_W = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
  localparam int WD_W = (WD_PERIODS < 2) ? 1 : $clog2(WD_PERIODS + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((WD_PERIODS > 0) ? (WD_PERIODS - 1) : 0);
  localparam logic [4:0]      CH_LIM  = 5'(CHANNELS);
  localparam bit              WD_EN   = (WD_PERIODS > 0);

`ifdef PWM_BANK_RAMP_EN
  localparam logic [WIDTH:0]   RAMP_WIDE = (WIDTH + 1)'(RAMP_STEP);
  localparam logic [WIDTH-1:0] RAMP_NARR = WIDTH'(RAMP_STEP);

  // Moves cur toward tgt by at most RAMP_STEP and lands exactly on tgt, never past it.
  function automatic logic [WIDTH-1:0] ramp_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0] diff;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      ramp_toward = (diff > RAMP_WIDE) ? (cur + RAMP_NARR) : tgt;
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      ramp_toward = (diff > RAMP_WIDE) ? (cur - RAMP_NARR) : tgt;
    end
  endfunction
`endif

  // All-ones duty saturates to a permanently high output.
  function automatic logic pwm_bit(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] duty);
    return (&duty) | (c < duty);
  endfunction

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    target_q [CHANNELS];
  logic [WIDTH-1:0]    target_d [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                wd_trip_q, wd_trip_d;
  logic                wr_err_q, wr_err_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                tick, wrap, ps, wr_hit, in_range, acc;

  always_comb begin
    tick     = (presc_q == PS_LAST);
    presc_d  = tick ? '0 : (presc_q + PS_W'(1));
    cnt_d    = tick ? (cnt_q + WIDTH'(1)) : cnt_q;
    wrap     = tick && (cnt_q == '1);
    ps       = wrap & ~rst;
    wr_hit   = wr_valid & ~rst;
    in_range = ({1'b0, wr_chan} < CH_LIM);
    acc      = wr_hit & in_range;
    wr_err_d = wr_hit & ~in_range;
    target_d  = target_q;
    active_d  = active_q;
    wd_cnt_d  = wd_cnt_q;
    wd_trip_d = wd_trip_q;

    // Active loads from the pre-write target, so a coincident write waits one period.
    if (ps) begin
      for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_BANK_RAMP_EN
        active_d[i] = ramp_toward(active_q[i], target_q[i]);
`else
        active_d[i] = target_q[i];
`endif
      end
    end

    for (int i = 0; i < CHANNELS; i++) begin
      if (acc && (wr_chan == 4'(i))) target_d[i] = wr_duty;
    end

    if (acc) begin
      wd_cnt_d  = '0;
      wd_trip_d = 1'b0;
    end else if (WD_EN && ps && !wd_trip_q) begin
      if (wd_cnt_q == WD_LAST) begin
        wd_cnt_d  = '0;
        wd_trip_d = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
          target_d[i] = '0;
          active_d[i] = '0;
        end
      end else begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end

    for (int i = 0; i < CHANNELS; i++) pwm_d[i] = pwm_bit(cnt_q, active_q[i]);
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      wd_cnt_q  <= '0;
      wd_trip_q <= 1'b0;
      wr_err_q  <= 1'b0;
      pwm_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        target_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      wd_trip_q <= wd_trip_d;
      wr_err_q  <= wr_err_d;
      pwm_q     <= pwm_d;
      target_q  <= target_d;
      active_q  <= active_d;
    end
  end

  assign wr_ready     = ~rst;
  assign wr_err       = wr_err_q;
  assign pwm_out      = pwm_q;
  assign period_start = ps;
  assign wd_trip      = wd_trip_q;

endmodule
